// File: rtl/req_pending_capture.sv
// Edge-captures 16 request lines into a pending mask for the priority encoder.
// Define REQ_OVERRUN_CNT_EN to add the saturating ovr_cnt overrun counter.
module req_pending_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_in,
    output logic [15:0] pend_mask,
    input  logic [7:0]  enc_code,
    output logic        out_valid,
    output logic [3:0]  out_idx,
    input  logic        out_ready
`ifdef REQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]  ovr_cnt
`endif
);

    localparam int NREQ = 16;
    localparam int IDXW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VALID  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [NREQ-1:0]   req_q;
    logic [NREQ-1:0]   rise;
    logic [NREQ-1:0]   clr;
    logic              enc_ok;
    logic              accept;
    logic              valid_n;
    logic [IDXW-1:0]   idx_n;

    assign rise   = req_in & ~req_q;
    assign enc_ok = (enc_code[7:4] == 4'd0);

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[out_idx] = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        valid_n = out_valid;
        idx_n   = out_idx;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc_ok) begin
                    valid_n = 1'b1;
                    idx_n   = enc_code[IDXW-1:0];
                    state_n = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    accept  = 1'b1;
                    valid_n = 1'b0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A rise on the bit being cleared this cycle keeps it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pend_mask <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            state     <= IDLE;
        end else begin
            req_q     <= req_in;
            pend_mask <= (pend_mask & ~clr) | rise;
            out_valid <= valid_n;
            out_idx   <= idx_n;
            state     <= state_n;
        end
    end

`ifdef REQ_OVERRUN_CNT_EN
    logic ovr_hit;

    assign ovr_hit = |(rise & pend_mask & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt <= '0;
        end else if (ovr_hit && (ovr_cnt != 8'hFF)) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_pending_capture.sv
// Directed bench for req_pending_capture with a behavioural priority encoder.
// Accepted indices are scored against a queue filled as requests are driven.
module tb_req_pending_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_in;
    logic [15:0] pend_mask;
    logic [7:0]  enc_code;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        out_ready;
`ifdef REQ_OVERRUN_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    req_pending_capture dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .pend_mask (pend_mask),
        .enc_code  (enc_code),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready)
`ifdef REQ_OVERRUN_CNT_EN
        ,
        .ovr_cnt   (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Highest set index wins; 8'hF0 when nothing is pending.
    always_comb begin
        enc_code = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            if (pend_mask[i]) enc_code = 8'(i);
        end
    end

    // Inputs are stable at negedge, so this sees exactly what the edge accepts.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL accept_unexpected: got idx %0d, expected none", out_idx);
            end
            if (exp_q.size() != 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                n_tests++;
                assert (out_idx === e) else begin
                    n_fail++;
                    $error("FAIL accept_idx: got %0d, expected %0d", out_idx, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [31:0] got, input logic [31:0] exp,
                         input string tag);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(pend_mask == 16'h0 && !out_valid) && n < budget) begin
            step();
            n++;
        end
        check(32'(pend_mask == 16'h0 && !out_valid), 32'd1, tag);
        check(32'(exp_q.size()), 32'd0, {tag, "_queue"});
    endtask

    initial begin
        // Reset held with all lines high
        rst       = 1'b1;
        req_in    = 16'hFFFF;
        out_ready = 1'b0;
        step();
        step();
        check(32'(pend_mask), 32'h0, "rst_pend");
        check(32'(out_valid), 32'h0, "rst_valid");
        check(32'(out_idx), 32'h0, "rst_idx");
        rst = 1'b0;
        step();
        check(32'(pend_mask), 32'hFFFF, "post_rst_pend");
        for (int i = 15; i >= 0; i--) exp_q.push_back(4'(i));
        out_ready = 1'b1;
        wait_idle(80, "drain_all");
        req_in    = 16'h0;
        out_ready = 1'b0;
        step();

        // Single pulse on bit 5
        req_in = 16'h0020;
        step();
        req_in = 16'h0;
        check(32'(pend_mask), 32'h0020, "single_pend");
        check(32'(out_valid), 32'h0, "single_valid_n1");
        step();
        check(32'(out_valid), 32'h1, "single_valid_n2");
        check(32'(out_idx), 32'd5, "single_idx");
        exp_q.push_back(4'd5);
        out_ready = 1'b1;
        step();
        check(32'(pend_mask), 32'h0, "single_clear");
        check(32'(out_valid), 32'h0, "single_valid_off");
        out_ready = 1'b0;
        step();
        step();

        // Bits 3 and 12 together, consumer always ready
        out_ready = 1'b1;
        exp_q.push_back(4'd12);
        exp_q.push_back(4'd3);
        req_in = 16'h1008;
        step();
        req_in = 16'h0;
        check(32'(pend_mask), 32'h1008, "order_pend");
        wait_idle(20, "order_drain");
        for (int i = 0; i < 3; i++) begin
            step();
            check(32'(out_valid), 32'h0, "order_stays_idle");
        end
        out_ready = 1'b0;

        // New rise on 12 in its own accept cycle
        req_in = 16'h1000;
        step();
        req_in = 16'h0;
        step();
        check(32'(out_idx), 32'd12, "setwin_first_idx");
        exp_q.push_back(4'd12);
        out_ready = 1'b1;
        req_in    = 16'h1000;
        step();
        req_in = 16'h0;
        check(32'(pend_mask), 32'h1000, "setwin_pend");
        check(32'(out_valid), 32'h0, "setwin_valid_off");
        exp_q.push_back(4'd12);
        step();
        step();
        check(32'(out_valid), 32'h1, "setwin_again_valid");
        check(32'(out_idx), 32'd12, "setwin_again_idx");
        step();
        check(32'(pend_mask), 32'h0, "setwin_clear");
        out_ready = 1'b0;
        step();
        step();

        // Stall with bit 9 held, plus a higher-priority pulse on 14
        req_in = 16'h0200;
        step();
        check(32'(pend_mask), 32'h0200, "stall_pend");
        step();
        for (int i = 0; i < 10; i++) begin
            req_in = (i == 3) ? 16'h4200 : 16'h0200;
            step();
            check(32'(out_valid), 32'h1, "stall_valid");
            check(32'(out_idx), 32'd9, "stall_idx");
        end
        check(32'(pend_mask), 32'h4200, "stall_pend_14");
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd14);
        out_ready = 1'b1;
        wait_idle(20, "stall_drain");
        for (int i = 0; i < 5; i++) begin
            step();
            check(32'(pend_mask), 32'h0, "level_no_repend");
            check(32'(out_valid), 32'h0, "level_no_valid");
        end
        req_in    = 16'h0;
        out_ready = 1'b0;
        step();

        // Repeated rises on bit 7 while stalled
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef REQ_OVERRUN_CNT_EN
        check(32'(ovr_cnt), 32'h0, "ovr_rst");
`endif
        for (int i = 0; i < 3; i++) begin
            req_in = 16'h0080;
            step();
            req_in = 16'h0;
            step();
        end
        check(32'(pend_mask), 32'h0080, "ovr_pend");
        check(32'(out_idx), 32'd7, "ovr_idx");
`ifdef REQ_OVERRUN_CNT_EN
        check(32'(ovr_cnt), 32'd2, "ovr_cnt_2");
        for (int i = 0; i < 300; i++) begin
            req_in = 16'h0080;
            step();
            req_in = 16'h0;
            step();
        end
        check(32'(ovr_cnt), 32'hFF, "ovr_cnt_sat");
`endif
        exp_q.push_back(4'd7);
        out_ready = 1'b1;
        wait_idle(10, "ovr_drain");
        out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
